hc595_chain_driver: RTL and testbench
=====================================

// Module: hc595_chain_driver
// PURPOSE
//  Parametrised serial driver for a daisy-chain of NUM_CHIPS 74HC595 shift registers.
//  Accepts one parallel frame per start/ready handshake, shifts it out on DS/SH_CP at a
//  programmable rate, then pulses ST_CP once to latch. Reports completion with a done pulse.
//  Sits between display/LED frame logic and the board-level 595 chain.
// PARAMETERS
//  NUM_CHIPS  2  number of chained 595s; NB = 8*NUM_CHIPS bits per frame (>=1)
//  DIV        4  clk cycles per SH_CP/ST_CP half-phase (>=1)
//  MSB_FIRST  1  1: data[NB-1] shifted first; 0: data[0] shifted first
// PORTS
//  clk    in   1   system clock, all logic on rising edge
//  rst    in   1   synchronous, active-high reset
//  start  in   1   frame request; accepted only when ready=1
//  data   in   NB  frame to send; sampled only in the accept cycle
//  blank  in   1   1 = disable 595 outputs (drives oe_n high)
//  ready  out  1   1 = idle, start will be accepted this cycle
//  done   out  1   one-cycle pulse when ST_CP latch phase completes
//  DS     out  1   serial data to first 595
//  SH_CP  out  1   shift clock (595 samples DS on rising edge)
//  ST_CP  out  1   storage latch clock
//  oe_n   out  1   registered copy of blank (active-low output enable)
// BEHAVIOUR
//  Reset values: ready=1, done=0, DS=0, SH_CP=0, ST_CP=0, oe_n=1; state IDLE, counters 0.
//  All outputs registered; oe_n follows blank with 1-cycle latency, independent of state.
//  States: IDLE -> SETUP -> HIGH -> (SETUP ... ) -> LATCH -> IDLE.
//   IDLE : ready=1, SH_CP=0, ST_CP=0. start&ready at edge k: capture data into shift reg,
//          bit_cnt=NB-1, go SETUP; ready=0 from cycle k+1.
//   SETUP: SH_CP=0, DS=current bit (set on entry, stable through SETUP and HIGH), DIV cycles.
//   HIGH : SH_CP=1 for DIV cycles. At end: bit_cnt==0 -> LATCH; else shift reg advances
//          one bit (left if MSB_FIRST, right otherwise), bit_cnt-1, -> SETUP.
//   LATCH: SH_CP=0, ST_CP=1 for DIV cycles, DS holds last bit; then -> IDLE with done=1,
//          ready=1 in that same cycle.
//  Latency: accept at edge k -> done high in cycle k+1+(2*NB+1)*DIV. Exactly NB SH_CP rising
//   edges and one ST_CP pulse per frame. Every DS change is >=DIV cycles before the next
//   SH_CP rise and occurs only while SH_CP=0.
//  Phase timer counts 0..DIV-1, wraps on phase change; width $clog2(DIV)+1; bit_cnt width
//   $clog2(NB)+1. DIV=1 legal (SH_CP period 2 clk).
//  start while ready=0: ignored, no queuing; data changes mid-frame have no effect.
//  start held high: next frame accepted in the done cycle (back-to-back, zero idle gap).
//  rst mid-frame: next edge returns to reset values; ST_CP not pulsed, so 595 outputs keep
//   the previously latched frame; partially shifted bits discarded on next full frame.
//  rst and start same cycle: rst wins, start dropped.
// TESTING
//  NUM_CHIPS=2, DIV=2, MSB_FIRST=1, data=16'hA5C3 -> DS at 16 SH_CP rises = 1010010111000011,
//   one ST_CP pulse 2 cycles wide after 16th rise, done at accept+67, ready same cycle.
//  Same, MSB_FIRST=0 -> DS sequence = 1100001110100101 (data[0] first), same timing.
//  start pulsed again mid-frame with data=16'hFFFF -> ignored, frame A5C3 completes
//   unchanged, single done pulse.
//  rst asserted after 5th SH_CP rise -> next cycle all outputs at reset values, no ST_CP
//   pulse ever seen, ready=1; new frame afterwards shifts all 16 bits correctly.
//  start held high, data 16'h0001 then 16'h8000, DIV=1 -> two frames back-to-back, second
//   accepted in first done cycle, 2 ST_CP pulses, no extra SH_CP edges.
//  blank toggled 0->1 during SHIFT -> oe_n follows 1 cycle later; DS/SH_CP/ST_CP unaffected.

Source files
------------

// File: rtl/hc595_chain_driver.sv
// hc595_chain_driver: shifts one parallel frame into a chain of 74HC595s,
// then pulses the storage latch and reports completion with a done pulse.
module hc595_chain_driver #(
    parameter int NUM_CHIPS = 2,
    parameter int DIV       = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*NUM_CHIPS-1:0] data,
    input  logic                   blank,
    output logic                   ready,
    output logic                   done,
    output logic                   DS,
    output logic                   SH_CP,
    output logic                   ST_CP,
    output logic                   oe_n
);

    localparam int NB = 8 * NUM_CHIPS;
    localparam int TW = $clog2(DIV) + 1;
    localparam int CW = $clog2(NB) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
    localparam logic [CW-1:0] C_LAST = CW'(NB - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HIGH,
        LATCH
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NB-1:0] sr_q, sr_d;
    logic [NB-1:0] sr_adv;
    logic          tmr_end;
    logic          ready_d, done_d, ds_d, sh_d, st_d;

    function automatic logic head_bit(input logic [NB-1:0] v);
        return MSB_FIRST ? v[NB-1] : v[0];
    endfunction

    assign tmr_end = (tmr_q == T_LAST);
    assign sr_adv  = MSB_FIRST ? {sr_q[NB-2:0], 1'b0}
                               : {1'b0, sr_q[NB-1:1]};

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        ready_d = ready;
        done_d  = 1'b0;
        ds_d    = DS;
        sh_d    = SH_CP;
        st_d    = ST_CP;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                sh_d    = 1'b0;
                st_d    = 1'b0;
                tmr_d   = '0;
                if (start && ready) begin
                    sr_d    = data;
                    cnt_d   = C_LAST;
                    ds_d    = head_bit(data);
                    ready_d = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tmr_end) begin
                    tmr_d   = '0;
                    sh_d    = 1'b1;
                    state_d = HIGH;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            HIGH: begin
                if (tmr_end) begin
                    tmr_d = '0;
                    sh_d  = 1'b0;
                    if (cnt_q == '0) begin
                        st_d    = 1'b1;
                        state_d = LATCH;
                    end else begin
                        // DS moves only on the falling SH_CP edge
                        sr_d    = sr_adv;
                        cnt_d   = cnt_q - 1'b1;
                        ds_d    = head_bit(sr_adv);
                        state_d = SETUP;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            LATCH: begin
                if (tmr_end) begin
                    tmr_d   = '0;
                    st_d    = 1'b0;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
            sr_q    <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
            DS      <= 1'b0;
            SH_CP   <= 1'b0;
            ST_CP   <= 1'b0;
            oe_n    <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            ready   <= ready_d;
            done    <= done_d;
            DS      <= ds_d;
            SH_CP   <= sh_d;
            ST_CP   <= st_d;
            oe_n    <= blank;
        end
    end

endmodule

// File: tb/tb_hc595_chain_driver.sv
// tb_hc595_chain_driver: three driver instances (DIV/bit-order variants)
// against a frame-level reference model and a scoreboard monitor.
module tb_hc595_chain_driver;

    localparam int NB = 16;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NI-1:0] start, blank;
    logic [NI-1:0] ready, done, ds, shcp, stcp, oen;
    logic [NB-1:0] data [NI];
    logic [NI-1:0] idle_w;
    int            nrise_w [NI];
    int            cyc    = 0;
    int            checks = 0;
    int            fails  = 0;
    bit            mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    for (genvar i = 0; i < NI; i++) begin : g
        localparam int DV  = (i == 2) ? 1 : 2;
        localparam bit MF  = (i == 1) ? 1'b0 : 1'b1;
        localparam int LAT = (2 * NB + 1) * DV;

        hc595_chain_driver #(
            .NUM_CHIPS(2),
            .DIV(DV),
            .MSB_FIRST(MF)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .start(start[i]),
            .data(data[i]),
            .blank(blank[i]),
            .ready(ready[i]),
            .done(done[i]),
            .DS(ds[i]),
            .SH_CP(shcp[i]),
            .ST_CP(stcp[i]),
            .oe_n(oen[i])
        );

        // reference: frame-level acceptance, expected bit order and done time
        logic [NB-1:0] q_seq [64];
        int            q_done [64];
        int            wr = 0;
        int            rd = 0;
        bit            mready = 1'b1;
        bit            moe = 1'b1;
        int            busy_end = 0;

        always @(posedge clk) begin : model
            int            e;
            logic [NB-1:0] s;
            e = cyc + 1;
            if (rst) begin
                mready   = 1'b1;
                moe      = 1'b1;
                busy_end = 0;
            end else begin
                moe = blank[i];
                if (mready && start[i]) begin
                    for (int b = 0; b < NB; b++)
                        s[b] = MF ? data[i][b] : data[i][NB-1-b];
                    q_seq[wr % 64]  = s;
                    q_done[wr % 64] = e + LAT;
                    wr++;
                    busy_end = e + LAT;
                    mready   = 1'b0;
                end else if (e >= busy_end) begin
                    mready = 1'b1;
                end
            end
        end

        logic [NB-1:0] got = '0;
        int            nrise = 0;
        int            last_ds = -100;
        int            st_at = 0;
        logic          p_sh = 1'b0, p_st = 1'b0, p_ds = 1'b0;

        always @(negedge clk) begin : mon
            string px;
            px = $sformatf("u%0d_", i);
            if (mon_en) begin
                chk_eq({px, "ready"}, ready[i], mready);
                chk_eq({px, "oe_n"}, oen[i], moe);
                if (ds[i] != p_ds) begin
                    chk_eq({px, "ds_change_sh_low"}, shcp[i], 0);
                    last_ds = cyc;
                end
                if (shcp[i] && !p_sh) begin
                    chk_eq({px, "ds_setup_ok"}, (cyc - last_ds) >= DV, 1);
                    got = {got[NB-2:0], ds[i]};
                    nrise++;
                end
                if (stcp[i] && !p_st) begin
                    st_at = cyc;
                    if (rd == wr) begin
                        chk_eq({px, "unexpected_latch"}, 1, 0);
                    end else begin
                        chk_eq({px, "shift_count"}, nrise, NB);
                        chk_eq({px, "frame_bits"}, got, q_seq[rd % 64]);
                    end
                end
                if (!stcp[i] && p_st)
                    chk_eq({px, "latch_width"}, cyc - st_at, DV);
                if (rd != wr && cyc == q_done[rd % 64]) begin
                    chk_eq({px, "done"}, done[i], 1);
                    rd++;
                    nrise = 0;
                end else if (done[i]) begin
                    chk_eq({px, "spurious_done"}, 1, 0);
                end
                if (rst) begin
                    rd    = wr;
                    nrise = 0;
                end
            end
            p_sh = shcp[i];
            p_st = stcp[i];
            p_ds = ds[i];
        end

        assign nrise_w[i] = nrise;
        assign idle_w[i]  = (rd == wr) && mready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input int i);
        chk_eq($sformatf("u%0d_rst_ready", i), ready[i], 1);
        chk_eq($sformatf("u%0d_rst_done", i), done[i], 0);
        chk_eq($sformatf("u%0d_rst_ds", i), ds[i], 0);
        chk_eq($sformatf("u%0d_rst_shcp", i), shcp[i], 0);
        chk_eq($sformatf("u%0d_rst_stcp", i), stcp[i], 0);
        chk_eq($sformatf("u%0d_rst_oe_n", i), oen[i], 1);
    endtask

    task automatic send(input int i, input logic [NB-1:0] d);
        data[i]  = d;
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int budget);
        int n;
        n = 0;
        while (!idle_w[i] && n < budget) begin
            tick();
            n++;
        end
        chk_eq($sformatf("u%0d_idle_in_time", i), idle_w[i], 1);
    endtask

    initial begin
        int n;
        start = '0;
        blank = '0;
        for (int i = 0; i < NI; i++) data[i] = '0;
        rst = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < NI; i++) chk_reset(i);
        rst    = 1'b0;
        mon_en = 1'b1;
        tick();

        // reference frame, then an ignored mid-frame request
        send(0, 16'hA5C3);
        repeat (20) tick();
        send(0, 16'hFFFF);
        wait_idle(0, 300);

        send(1, 16'hA5C3);
        wait_idle(1, 300);

        // reset after the fifth shift clock: frame abandoned, no latch
        send(0, 16'h5A3C);
        n = 0;
        while (nrise_w[0] < 5 && n < 200) begin
            tick();
            n++;
        end
        chk_eq("u0_reached_5_shifts", nrise_w[0] >= 5, 1);
        rst = 1'b1;
        tick();
        chk_reset(0);
        rst = 1'b0;
        tick();
        send(0, 16'h3C5A);
        wait_idle(0, 300);

        // start held high: second frame taken in the done cycle
        data[2]  = 16'h0001;
        start[2] = 1'b1;
        tick();
        data[2] = 16'h8000;
        n = 0;
        while (!done[2] && n < 200) begin
            tick();
            n++;
        end
        chk_eq("u2_first_done_seen", done[2], 1);
        tick();
        start[2] = 1'b0;
        wait_idle(2, 300);

        // blank toggled mid-shift
        send(0, 16'hC0DE);
        repeat (10) tick();
        blank[0] = 1'b1;
        repeat (7) tick();
        blank[0] = 1'b0;
        wait_idle(0, 300);

        // random traffic on all instances
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NI; i++) begin
                start[i] = ($urandom % 8) == 0;
                data[i]  = NB'($urandom);
                if (($urandom % 16) == 0) blank[i] = ~blank[i];
            end
            tick();
        end
        start = '0;
        for (int i = 0; i < NI; i++) wait_idle(i, 300);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
